ddr2_cmd_monitor: RTL and testbench
===================================

# ddr2_cmd_monitor

Parametrised, passive DDR2 command-bus monitor. It sits beside the controller-to-device interface in simulation and in FPGA debug builds. It decodes every command, tracks per-bank open/closed state, checks core timing intervals with per-bank counters, and flags protocol violations. It never drives the DDR2 bus.

## Interface
Parameters:
- BA_BITS, 3, bank address width; NUM_BANKS = 2**BA_BITS
- ADDR_BITS, 14, row/column address width; addr[10] is the auto-precharge/all-bank bit
- T_RCD, 3, minimum cycles from ACT to RD/WR, same bank
- T_RP, 3, minimum cycles from PRE to ACT, same bank
- T_RAS, 8, minimum cycles from ACT to PRE, same bank
- T_RFC, 26, minimum cycles from REF to any non-NOP command
- T_MRD, 2, minimum cycles from MRS to any non-NOP command
- TW, 6, timer width; must hold max(T_*)
- CNT_W, 16, statistics counter width

Ports:
- ck  in  1  clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- cke, cs_n, ras_n, cas_n, we_n  in  1 each  sampled DDR2 control
- ba  in  BA_BITS  bank address
- addr  in  ADDR_BITS  address
- cmd_valid  out  1  pulse: a non-NOP command was decoded
- cmd_code  out  3  1 MRS, 2 REF, 3 PRE, 4 ACT, 5 WR, 6 RD
- cmd_bank  out  BA_BITS  bank of the decoded command
- viol  out  1  pulse: violation on this command
- viol_code  out  3  violation type (see Operation)
- viol_bank  out  BA_BITS  offending bank
- bank_open  out  NUM_BANKS  per-bank open flag
- mrs_seen  out  1  sticky flag; set at the first MRS
- clr_stat  in  1  synchronous clear of the statistics counters
- act_cnt, rd_cnt, wr_cnt, ref_cnt  out  CNT_W each  command counts (macro-gated)

## Operation
- Decode applies only when cke=1 and cs_n=0. The nibble {cs_n,ras_n,cas_n,we_n} maps as follows: 0000 MRS, 0001 REF, 0010 PRE, 0011 ACT, 0100 WR, 0101 RD. 0111 (NOP), deselect, and cke=0 produce no command.
- Bank state:
  - ACT opens bank ba.
  - PRE with addr[10]=1 closes all banks; with addr[10]=0 it closes bank ba.
  - RD/WR with addr[10]=1 closes bank ba (auto-precharge). In that case the T_RP timer for bank ba restarts as for a PRE.
- Per-bank timers (TW bits, saturating at all-ones): t_act[b] clears on ACT to b; t_pre[b] clears on a PRE or auto-precharge that closes b.
- Global timers: t_ref clears on REF; t_mrd clears on MRS.
- Every timer counts up by 1 per cycle. Each timer resets to all-ones, so the first command after reset is never a timing violation.
- Distance d is the number of cycles between the two command edges.
- Violation codes, checked on each command; the lowest applicable code is reported:
  - 1 tMRD: any command with t_mrd < T_MRD
  - 2 tRFC: any command with t_ref < T_RFC
  - 3 REF while any bank is open
  - 4 ACT to an open bank, or ACT with t_pre[ba] < T_RP
  - 5 RD/WR to a closed bank
  - 6 tRCD: RD/WR with t_act[ba] < T_RCD
  - 7 tRAS: PRE with t_act < T_RAS on any bank it closes
- PRE-all reports the lowest-index offending bank. PRE to an already-closed bank is legal.
- State updates are applied even when the command violates a check, so the monitor tracks the device's actual behaviour.

## Timing
- Latency is one cycle. A command sampled at edge N drives cmd_*, viol_*, and the updated bank_open during cycle N+1 (registered).
- cmd_valid and viol are single-cycle pulses. Back-to-back commands produce back-to-back pulses.
- Reset values: cmd_valid=0, cmd_code=0, cmd_bank=0, viol=0, viol_code=0, viol_bank=0, bank_open=0, mrs_seen=0, all stat counters=0. All timers reset to all-ones.
- Reset asserted mid-sequence returns everything to reset values immediately (asynchronous). The first command after release decodes normally.
- Statistics counters saturate at 2**CNT_W-1. clr_stat has priority over a same-cycle increment.

## Configuration
- Macro DDR2_MON_STAT_EN.
- Defined: act_cnt/rd_cnt/wr_cnt/ref_cnt count decoded commands, including commands that violate a check.
- Undefined: the counters and their logic are removed. The ports remain and are tied to 0.

## Test plan
- Reset, then MRS at edge 5 and ACT bank0 at edge 6 (T_MRD=2) -> viol=1, viol_code=1 at cycle 7; mrs_seen=1; bank_open=8'b0000_0001.
- ACT bank2 at edge 10, RD bank2 at edge 12 -> viol_code=6, viol_bank=2. Repeat with RD at edge 13 -> cmd_valid=1, cmd_code=6, viol=0.
- ACT banks 1 and 3, wait 10 cycles, PRE with addr[10]=1 -> no violation, bank_open=0. Then ACT bank1 on the next cycle -> viol_code=4 (tRP).
- REF with bank5 open -> viol_code=3. After PRE and then REF, any command within 25 cycles -> viol_code=2; the same command at 26 cycles -> clean.
- WR bank4 with no prior ACT -> viol_code=5, viol_bank=4. Hold cke=0 and drive RD encodings -> cmd_valid stays 0.
- With DDR2_MON_STAT_EN: issue 3 ACT, 2 RD, 1 WR, 1 REF -> counters read 3/2/1/1. Pulse clr_stat -> all 0. Assert rst_n low mid-burst -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/ddr2_cmd_monitor.sv
// Passive DDR2 command-bus monitor: decodes commands, tracks per-bank state and timing, flags violations.
// Optional command statistics counters are built only when DDR2_MON_STAT_EN is defined.
module ddr2_cmd_monitor #(
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 14,
  parameter int T_RCD     = 3,
  parameter int T_RP      = 3,
  parameter int T_RAS     = 8,
  parameter int T_RFC     = 26,
  parameter int T_MRD     = 2,
  parameter int TW        = 6,
  parameter int CNT_W     = 16,
  localparam int NUM_BANKS = 2 ** BA_BITS
) (
  input  logic                 ck,
  input  logic                 rst_n,
  input  logic                 cke,
  input  logic                 cs_n,
  input  logic                 ras_n,
  input  logic                 cas_n,
  input  logic                 we_n,
  input  logic [BA_BITS-1:0]   ba,
  input  logic [ADDR_BITS-1:0] addr,
  output logic                 cmd_valid,
  output logic [2:0]           cmd_code,
  output logic [BA_BITS-1:0]   cmd_bank,
  output logic                 viol,
  output logic [2:0]           viol_code,
  output logic [BA_BITS-1:0]   viol_bank,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic                 mrs_seen,
  input  logic                 clr_stat,
  output logic [CNT_W-1:0]     act_cnt,
  output logic [CNT_W-1:0]     rd_cnt,
  output logic [CNT_W-1:0]     wr_cnt,
  output logic [CNT_W-1:0]     ref_cnt
);
  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_MRS  = 3'd1;
  localparam logic [2:0] C_REF  = 3'd2;
  localparam logic [2:0] C_PRE  = 3'd3;
  localparam logic [2:0] C_ACT  = 3'd4;
  localparam logic [2:0] C_WR   = 3'd5;
  localparam logic [2:0] C_RD   = 3'd6;
  localparam logic [TW-1:0] T_SAT = '1;

  logic [2:0]           code;
  logic                 is_rw;
  logic                 a10;
  logic [NUM_BANKS-1:0] ba_sel, act_mask, close_mask;
  logic [NUM_BANKS-1:0] bank_open_q, bank_open_d;
  logic [NUM_BANKS-1:0] rcd_short, rp_short, ras_short, ras_hit;
  logic [TW-1:0]        t_ref_q, t_mrd_q;
  logic                 mrd_short, rfc_short;
  logic [2:0]           viol_code_d;
  logic [BA_BITS-1:0]   viol_bank_d;
  logic                 cmd_valid_q, viol_q, mrs_seen_q;
  logic [2:0]           cmd_code_q, viol_code_q;
  logic [BA_BITS-1:0]   cmd_bank_q, viol_bank_q;
  logic                 unused_addr;

  // Timers hold the edge distance since their last event: loaded with 1 so the
  // value seen at the next command edge equals d, then saturate at all-ones.
  function automatic logic [TW-1:0] tick(input logic [TW-1:0] t, input logic restart);
    if (restart)         return TW'(1);
    else if (t == T_SAT) return t;
    else                 return t + 1'b1;
  endfunction

  function automatic logic [BA_BITS-1:0] lowest(input logic [NUM_BANKS-1:0] v);
    logic [BA_BITS-1:0] idx;
    idx = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (v[i]) idx = BA_BITS'(i);
    end
    return idx;
  endfunction

  always_comb begin
    code = C_NONE;
    if (cke && !cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b000:  code = C_MRS;
        3'b001:  code = C_REF;
        3'b010:  code = C_PRE;
        3'b011:  code = C_ACT;
        3'b100:  code = C_WR;
        3'b101:  code = C_RD;
        default: code = C_NONE;
      endcase
    end
  end

  assign a10         = addr[10];
  assign unused_addr = ^{addr[ADDR_BITS-1:11], addr[9:0]};
  assign is_rw       = (code == C_RD) || (code == C_WR);
  assign ba_sel      = NUM_BANKS'(1) << ba;
  assign act_mask    = (code == C_ACT) ? ba_sel : '0;

  always_comb begin
    close_mask = '0;
    if (code == C_PRE)     close_mask = a10 ? '1 : ba_sel;
    else if (is_rw && a10) close_mask = ba_sel;
  end

  assign bank_open_d = (bank_open_q & ~close_mask) | act_mask;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [TW-1:0] t_act_q, t_pre_q;

    always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
        t_act_q <= T_SAT;
        t_pre_q <= T_SAT;
      end else begin
        t_act_q <= tick(t_act_q, act_mask[gi]);
        t_pre_q <= tick(t_pre_q, close_mask[gi]);
      end
    end

    assign rcd_short[gi] = t_act_q < TW'(T_RCD);
    assign ras_short[gi] = t_act_q < TW'(T_RAS);
    assign rp_short[gi]  = t_pre_q < TW'(T_RP);
  end

  assign mrd_short = t_mrd_q < TW'(T_MRD);
  assign rfc_short = t_ref_q < TW'(T_RFC);
  // tRAS only concerns banks that this PRE actually closes (open ones).
  assign ras_hit   = (code == C_PRE) ? (close_mask & bank_open_q & ras_short) : '0;

  always_comb begin
    viol_code_d = 3'd0;
    viol_bank_d = '0;
    if (code != C_NONE) begin
      if (mrd_short) begin
        viol_code_d = 3'd1;
        viol_bank_d = ba;
      end else if (rfc_short) begin
        viol_code_d = 3'd2;
        viol_bank_d = ba;
      end else if (code == C_REF && |bank_open_q) begin
        viol_code_d = 3'd3;
        viol_bank_d = lowest(bank_open_q);
      end else if (code == C_ACT && (bank_open_q[ba] || rp_short[ba])) begin
        viol_code_d = 3'd4;
        viol_bank_d = ba;
      end else if (is_rw && !bank_open_q[ba]) begin
        viol_code_d = 3'd5;
        viol_bank_d = ba;
      end else if (is_rw && rcd_short[ba]) begin
        viol_code_d = 3'd6;
        viol_bank_d = ba;
      end else if (|ras_hit) begin
        viol_code_d = 3'd7;
        viol_bank_d = lowest(ras_hit);
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 3'd0;
      cmd_bank_q  <= '0;
      viol_q      <= 1'b0;
      viol_code_q <= 3'd0;
      viol_bank_q <= '0;
      bank_open_q <= '0;
      mrs_seen_q  <= 1'b0;
      t_ref_q     <= T_SAT;
      t_mrd_q     <= T_SAT;
    end else begin
      cmd_valid_q <= (code != C_NONE);
      viol_q      <= (viol_code_d != 3'd0);
      if (code != C_NONE) begin
        cmd_code_q  <= code;
        cmd_bank_q  <= ba;
        viol_code_q <= viol_code_d;
        viol_bank_q <= viol_bank_d;
      end
      bank_open_q <= bank_open_d;
      if (code == C_MRS) mrs_seen_q <= 1'b1;
      t_ref_q <= tick(t_ref_q, code == C_REF);
      t_mrd_q <= tick(t_mrd_q, code == C_MRS);
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_bank  = cmd_bank_q;
  assign viol      = viol_q;
  assign viol_code = viol_code_q;
  assign viol_bank = viol_bank_q;
  assign bank_open = bank_open_q;
  assign mrs_seen  = mrs_seen_q;

`ifdef DDR2_MON_STAT_EN
  logic [CNT_W-1:0] act_cnt_q, rd_cnt_q, wr_cnt_q, ref_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic hit);
    return (hit && (c != '1)) ? c + 1'b1 : c;
  endfunction

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      act_cnt_q <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      ref_cnt_q <= '0;
    end else if (clr_stat) begin
      act_cnt_q <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      ref_cnt_q <= '0;
    end else begin
      act_cnt_q <= sat_inc(act_cnt_q, code == C_ACT);
      rd_cnt_q  <= sat_inc(rd_cnt_q,  code == C_RD);
      wr_cnt_q  <= sat_inc(wr_cnt_q,  code == C_WR);
      ref_cnt_q <= sat_inc(ref_cnt_q, code == C_REF);
    end
  end

  assign act_cnt = act_cnt_q;
  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;
  assign ref_cnt = ref_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_stat;
  assign act_cnt    = '0;
  assign rd_cnt     = '0;
  assign wr_cnt     = '0;
  assign ref_cnt    = '0;
`endif

endmodule

// File: tb/tb_ddr2_cmd_monitor.sv
// Scoreboard bench for ddr2_cmd_monitor: a distance-based reference model predicts each cycle's outputs.
module tb_ddr2_cmd_monitor;
  localparam int NB    = 8;
  localparam int T_RCD = 3;
  localparam int T_RP  = 3;
  localparam int T_RAS = 8;
  localparam int T_RFC = 26;
  localparam int T_MRD = 2;
  localparam int FAR   = -100000;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic        cke = 1'b1, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [2:0]  ba = '0;
  logic [13:0] addr = '0;
  logic        clr_stat = 1'b0;
  logic        cmd_valid, viol, mrs_seen;
  logic [2:0]  cmd_code, cmd_bank, viol_code, viol_bank;
  logic [7:0]  bank_open;
  logic [15:0] act_cnt, rd_cnt, wr_cnt, ref_cnt;

  always #5 ck = ~ck;

  ddr2_cmd_monitor dut (
    .ck(ck), .rst_n(rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bank(cmd_bank),
    .viol(viol), .viol_code(viol_code), .viol_bank(viol_bank), .bank_open(bank_open),
    .mrs_seen(mrs_seen), .clr_stat(clr_stat), .act_cnt(act_cnt), .rd_cnt(rd_cnt),
    .wr_cnt(wr_cnt), .ref_cnt(ref_cnt)
  );

  typedef struct {
    bit       valid;
    int       code;
    int       bank;
    int       vcode;
    int       vbank;
    bit [7:0] open;
    bit       mrs;
    int       na, nr, nw, nf;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;

  // Reference state: edge number of the last event of each kind, plus open flags.
  int   n = 0;
  int   last_act[NB], last_pre[NB];
  int   last_ref, last_mrs;
  bit   m_open[NB];
  bit   m_mrs;
  int   c_act, c_rd, c_wr, c_ref;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int b = 0; b < NB; b++) begin
      last_act[b] = FAR;
      last_pre[b] = FAR;
      m_open[b]   = 1'b0;
    end
    last_ref = FAR;
    last_mrs = FAR;
    m_mrs    = 1'b0;
    c_act = 0; c_rd = 0; c_wr = 0; c_ref = 0;
  endfunction

  function automatic void model_step(input bit k, input bit cs, input logic [2:0] rcw,
                                     input int b, input bit a10, input bit clr);
    exp_t e;
    int   cmd;
    bit   any_open;
    cmd = 0;
    if (k && !cs) begin
      case (rcw)
        3'b000:  cmd = 1;
        3'b001:  cmd = 2;
        3'b010:  cmd = 3;
        3'b011:  cmd = 4;
        3'b100:  cmd = 5;
        3'b101:  cmd = 6;
        default: cmd = 0;
      endcase
    end
    n++;
    any_open = 1'b0;
    for (int i = 0; i < NB; i++) any_open |= m_open[i];
    e.valid = (cmd != 0);
    e.code  = cmd;
    e.bank  = b;
    e.vcode = 0;
    e.vbank = -1;
    if (cmd != 0) begin
      if (n - last_mrs < T_MRD) e.vcode = 1;
      else if (n - last_ref < T_RFC) e.vcode = 2;
      else if (cmd == 2 && any_open) e.vcode = 3;
      else if (cmd == 4 && (m_open[b] || n - last_pre[b] < T_RP)) begin e.vcode = 4; e.vbank = b; end
      else if ((cmd == 5 || cmd == 6) && !m_open[b]) begin e.vcode = 5; e.vbank = b; end
      else if ((cmd == 5 || cmd == 6) && n - last_act[b] < T_RCD) begin e.vcode = 6; e.vbank = b; end
      else if (cmd == 3) begin
        for (int i = 0; i < NB; i++) begin
          if (e.vcode == 0 && (a10 || i == b) && m_open[i] && n - last_act[i] < T_RAS) begin
            e.vcode = 7;
            e.vbank = i;
          end
        end
      end
    end
    case (cmd)
      1: begin last_mrs = n; m_mrs = 1'b1; end
      2: last_ref = n;
      3: for (int i = 0; i < NB; i++) if (a10 || i == b) begin m_open[i] = 1'b0; last_pre[i] = n; end
      4: begin m_open[b] = 1'b1; last_act[b] = n; end
      5, 6: if (a10) begin m_open[b] = 1'b0; last_pre[b] = n; end
      default: ;
    endcase
`ifdef DDR2_MON_STAT_EN
    if (clr) begin
      c_act = 0; c_rd = 0; c_wr = 0; c_ref = 0;
    end else begin
      if (cmd == 4) c_act++;
      if (cmd == 6) c_rd++;
      if (cmd == 5) c_wr++;
      if (cmd == 2) c_ref++;
    end
`endif
    for (int i = 0; i < NB; i++) e.open[i] = m_open[i];
    e.mrs = m_mrs;
    e.na = c_act; e.nr = c_rd; e.nw = c_wr; e.nf = c_ref;
    expq.push_back(e);
  endfunction

  function automatic logic [2:0] enc(input int c);
    case (c)
      1:       return 3'b000;
      2:       return 3'b001;
      3:       return 3'b010;
      4:       return 3'b011;
      5:       return 3'b100;
      6:       return 3'b101;
      default: return 3'b111;
    endcase
  endfunction

  task automatic drive(input bit k, input bit cs, input logic [2:0] rcw, input int b,
                       input bit a10, input bit clr);
    @(negedge ck);
    cke = k;
    cs_n = cs;
    {ras_n, cas_n, we_n} = rcw;
    ba = b[2:0];
    addr = 14'($urandom);
    addr[10] = a10;
    clr_stat = clr;
    model_step(k, cs, rcw, b, a10, clr);
  endtask

  task automatic cmd(input int c, input int b, input bit a10);
    drive(1'b1, 1'b0, enc(c), b, a10, 1'b0);
  endtask

  task automatic idle(input int k);
    repeat (k) cmd(0, 0, 1'b0);
  endtask

  task automatic after_edge();
    @(posedge ck);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_cmd_code"}, cmd_code, 0);
    chk({tag, "_cmd_bank"}, cmd_bank, 0);
    chk({tag, "_viol"}, viol, 0);
    chk({tag, "_viol_code"}, viol_code, 0);
    chk({tag, "_viol_bank"}, viol_bank, 0);
    chk({tag, "_bank_open"}, bank_open, 0);
    chk({tag, "_mrs_seen"}, mrs_seen, 0);
    chk({tag, "_cnts"}, {act_cnt, rd_cnt} | {wr_cnt, ref_cnt}, 0);
  endtask

  // Monitor: each cycle's registered outputs are compared with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      after_edge();
      if (rst_n && expq.size() > 0) begin
        e = expq.pop_front();
        chk("cmd_valid", cmd_valid, e.valid);
        if (e.valid) begin
          $display("txn code=%0d bank=%0d viol=%0d viol_code=%0d viol_bank=%0d",
                   cmd_code, cmd_bank, viol, viol_code, viol_bank);
          chk("cmd_code", cmd_code, e.code);
          chk("cmd_bank", cmd_bank, e.bank);
          chk("viol", viol, e.vcode != 0);
          chk("viol_code", viol_code, e.vcode);
          if (e.vbank >= 0) chk("viol_bank", viol_bank, e.vbank);
        end else begin
          chk("viol_idle", viol, 0);
        end
        chk("bank_open", bank_open, e.open);
        chk("mrs_seen", mrs_seen, e.mrs);
        chk("act_cnt", act_cnt, e.na);
        chk("rd_cnt", rd_cnt, e.nr);
        chk("wr_cnt", wr_cnt, e.nw);
        chk("ref_cnt", ref_cnt, e.nf);
      end
    end
  end

  initial begin
    int tbl[10];
    int r, c, ea, er, ew, ef;
    tbl = '{3, 3, 3, 4, 4, 4, 5, 5, 6, 6};
    model_reset();
    #3;
    chk_all_zero("reset");
    repeat (2) @(negedge ck);
    rst_n = 1'b1;
    idle(3);

    cmd(1, 0, 1'b0); cmd(4, 0, 1'b0); after_edge();
    chk("tmrd_viol", viol, 1);
    chk("tmrd_code", viol_code, 1);
    chk("tmrd_mrs_seen", mrs_seen, 1);
    chk("tmrd_open", bank_open, 8'h01);

    idle(3);
    cmd(4, 2, 1'b0); idle(1); cmd(6, 2, 1'b0); after_edge();
    chk("trcd_code", viol_code, 6);
    chk("trcd_bank", viol_bank, 2);
    cmd(6, 2, 1'b0); after_edge();
    chk("rd_ok_valid", cmd_valid, 1);
    chk("rd_ok_code", cmd_code, 6);
    chk("rd_ok_viol", viol, 0);

    idle(8); cmd(3, 0, 1'b1); idle(3);
    cmd(4, 1, 1'b0); cmd(4, 3, 1'b0); idle(10); cmd(3, 0, 1'b1); after_edge();
    chk("preall_viol", viol, 0);
    chk("preall_open", bank_open, 0);
    cmd(4, 1, 1'b0); after_edge();
    chk("trp_code", viol_code, 4);
    chk("trp_bank", viol_bank, 1);

    idle(3); cmd(4, 5, 1'b0); cmd(2, 0, 1'b0); after_edge();
    chk("ref_open_code", viol_code, 3);
    idle(26); cmd(3, 0, 1'b1); cmd(2, 0, 1'b0); after_edge();
    chk("ref_clean", viol, 0);
    idle(24); cmd(3, 0, 1'b0); after_edge();
    chk("trfc_d25_code", viol_code, 2);
    cmd(3, 0, 1'b0); after_edge();
    chk("trfc_d26_valid", cmd_valid, 1);
    chk("trfc_d26_viol", viol, 0);

    cmd(5, 4, 1'b0); after_edge();
    chk("wr_closed_code", viol_code, 5);
    chk("wr_closed_bank", viol_bank, 4);
    repeat (3) begin
      drive(1'b0, 1'b0, 3'b101, 6, 1'b0, 1'b0); after_edge();
      chk("cke_low_valid", cmd_valid, 0);
    end

    drive(1'b1, 1'b0, 3'b111, 0, 1'b0, 1'b1); after_edge();
    chk("clr_act", act_cnt, 0);
    chk("clr_ref", ref_cnt, 0);
    cmd(4, 0, 1'b0); cmd(4, 1, 1'b0); cmd(4, 2, 1'b0);
    cmd(6, 0, 1'b0); cmd(6, 1, 1'b0); cmd(5, 2, 1'b0); cmd(2, 0, 1'b0); after_edge();
`ifdef DDR2_MON_STAT_EN
    ea = 3; er = 2; ew = 1; ef = 1;
`else
    ea = 0; er = 0; ew = 0; ef = 0;
`endif
    chk("stat_act", act_cnt, ea);
    chk("stat_rd", rd_cnt, er);
    chk("stat_wr", wr_cnt, ew);
    chk("stat_ref", ref_cnt, ef);
    drive(1'b1, 1'b0, enc(4), 3, 1'b0, 1'b1); after_edge();
    chk("clr_priority", act_cnt, 0);

    idle(30);
    cmd(4, 5, 1'b0); cmd(6, 6, 1'b0); after_edge();
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    cke = 1'b1; cs_n = 1'b1; clr_stat = 1'b0;
    repeat (2) @(negedge ck);
    expq.delete();
    model_reset();
    rst_n = 1'b1;

    repeat (450) begin
      r = $urandom_range(0, 99);
      if (r < 8)       drive(1'b0, 1'b0, 3'($urandom), $urandom_range(0, 7), 1'($urandom), 1'b0);
      else if (r < 14) drive(1'b1, 1'b1, 3'($urandom), $urandom_range(0, 7), 1'($urandom), 1'b0);
      else if (r < 40) idle(1);
      else if (r < 43) drive(1'b1, 1'b0, 3'b110, $urandom_range(0, 7), 1'($urandom), 1'b0);
      else if (r < 45) drive(1'b1, 1'b0, enc(1), $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)));
      else if (r < 47) cmd(2, 0, 1'b0);
      else begin
        c = tbl[$urandom_range(0, 9)];
        drive(1'b1, 1'b0, enc(c), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 29) == 0));
      end
    end
    idle(1);
    after_edge();
    after_edge();
    chk("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
